// File: rtl/cov_mon_pkg.sv
// rtl/cov_mon_pkg.sv - shared types, default constants and helpers for the coverage stall monitor
package cov_mon_pkg;

    typedef enum logic {
        ARMED = 1'b0,
        FIRED = 1'b1
    } mon_state_t;

    localparam int DEF_NCH         = 2;
    localparam int DEF_COV_W       = 30;
    localparam int DEF_CNT_W       = 32;
    localparam int DEF_BASE_WAIT   = 1000;
    localparam int DEF_SCALE_SHIFT = 19;
    localparam int DEF_WDOG_LIMIT  = 50000;

    // Full-precision product clamped to all-ones of width w (w <= 64).
    function automatic logic [63:0] sat_mul(
        input logic [63:0] a,
        input logic [63:0] b,
        input int unsigned w
    );
        logic [127:0] prod;
        logic [127:0] lim;
        prod = {64'd0, a} * {64'd0, b};
        lim  = (128'd1 << w) - 128'd1;
        return (prod > lim) ? lim[63:0] : prod[63:0];
    endfunction

endpackage

// File: rtl/cov_stall_channel.sv
// rtl/cov_stall_channel.sv - one coverage channel: change detect, scaled threshold, stall counter
module cov_stall_channel
    import cov_mon_pkg::*;
#(
    parameter int COV_W       = DEF_COV_W,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int BASE_WAIT   = DEF_BASE_WAIT,
    parameter int SCALE_SHIFT = DEF_SCALE_SHIFT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic [COV_W-1:0] cov,
    output logic             hit
);

    logic [COV_W-1:0] pre_cov;
    logic [CNT_W-1:0] stall;
    logic [CNT_W-1:0] thr;
    logic [COV_W:0]   mult;
    logic [CNT_W-1:0] thr_next;
    logic             changed;

    assign changed  = (cov != pre_cov);
    assign mult     = (COV_W+1)'(cov >> SCALE_SHIFT) + (COV_W+1)'(1);
    assign thr_next = CNT_W'(sat_mul(64'(BASE_WAIT), 64'(mult), CNT_W));
    assign hit      = (stall >= thr);

    always_ff @(posedge clock) begin
        if (!reset) begin
            pre_cov <= '0;
            stall   <= '0;
            thr     <= CNT_W'(BASE_WAIT);
        end else begin
            if (en && changed) begin
                pre_cov <= cov;
                thr     <= thr_next;
                stall   <= '0;
            end else if (en && (stall != '1)) begin
                stall <= stall + CNT_W'(1);
            end
            // Clear must beat a same-cycle increment.
            if (clr) begin
                stall <= '0;
            end
        end
    end

endmodule

// File: rtl/cov_stall_monitor.sv
// rtl/cov_stall_monitor.sv - multi-channel coverage stall monitor with watchdog and sticky irq
module cov_stall_monitor
    import cov_mon_pkg::*;
#(
    parameter int NCH         = DEF_NCH,
    parameter int COV_W       = DEF_COV_W,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int BASE_WAIT   = DEF_BASE_WAIT,
    parameter int SCALE_SHIFT = DEF_SCALE_SHIFT,
    parameter int WDOG_LIMIT  = DEF_WDOG_LIMIT
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [NCH*COV_W-1:0] cov,
    input  logic                 done,
    input  logic                 irq_ack,
    output logic                 irq,
    output logic [NCH:0]         cause,
    output logic [15:0]          fire_count
);

    logic [NCH-1:0]   hit;
    logic             hit_w;
    logic [CNT_W-1:0] wdog;
    logic [15:0]      fire_count_q;
    logic             clr;
    logic             fire;
    mon_state_t       st;
    mon_state_t       st_next;

    // An ack only counts while an interrupt is outstanding.
    assign clr        = done | ((st == FIRED) & irq_ack);
    assign hit_w      = (wdog >= CNT_W'(WDOG_LIMIT));
    assign fire_count = fire_count_q;

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        cov_stall_channel #(
            .COV_W      (COV_W),
            .CNT_W      (CNT_W),
            .BASE_WAIT  (BASE_WAIT),
            .SCALE_SHIFT(SCALE_SHIFT)
        ) u_ch (
            .clock(clock),
            .reset(reset),
            .en   (enable),
            .clr  (clr),
            .cov  (cov[g*COV_W +: COV_W]),
            .hit  (hit[g])
        );
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            st <= ARMED;
        end else begin
            st <= st_next;
        end
    end

    always_comb begin
        st_next = st;
        fire    = 1'b0;
        case (st)
            ARMED: begin
                if (enable && (hit_w || (|hit)) && !clr) begin
                    st_next = FIRED;
                    fire    = 1'b1;
                end
            end
            FIRED: begin
                if (clr) begin
                    st_next = ARMED;
                end
            end
            default: st_next = ARMED;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            wdog         <= '0;
            irq          <= 1'b0;
            cause        <= '0;
            fire_count_q <= '0;
        end else begin
            if (clr) begin
                wdog <= '0;
            end else if (enable && (wdog != '1)) begin
                wdog <= wdog + CNT_W'(1);
            end
            if (fire) begin
                irq   <= 1'b1;
                cause <= {hit_w, hit};
                if (fire_count_q != 16'hFFFF) begin
                    fire_count_q <= fire_count_q + 16'd1;
                end
            end else if ((st == FIRED) && clr) begin
                irq   <= 1'b0;
                cause <= '0;
            end
        end
    end

endmodule

// File: tb/tb_cov_stall_monitor.sv
// tb/tb_cov_stall_monitor.sv - directed and randomized bench for cov_stall_monitor against a reference model
module tb_cov_stall_monitor;

    localparam int NCH = 2;
    localparam int COV_W = 8;
    localparam int CNT_W = 32;
    localparam int BW = 4;
    localparam int SS = 4;
    localparam int WL = 20;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic        done = 1'b0;
    logic        irq_ack = 1'b0;
    logic [15:0] cov = '0;
    logic        irq;
    logic [2:0]  cause;
    logic [15:0] fire_count;

    int n_vec = 0;
    int n_err = 0;

    int       m_pre[NCH];
    int       m_stall[NCH];
    int       m_thr[NCH];
    int       m_wdog;
    bit       m_fired;
    logic [2:0] m_cause;
    int       m_cnt;

    cov_stall_monitor #(
        .NCH(NCH), .COV_W(COV_W), .CNT_W(CNT_W),
        .BASE_WAIT(BW), .SCALE_SHIFT(SS), .WDOG_LIMIT(WL)
    ) dut (
        .clock(clock), .reset(reset), .enable(enable), .cov(cov),
        .done(done), .irq_ack(irq_ack), .irq(irq), .cause(cause),
        .fire_count(fire_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Behavioural view of one clock edge, evaluated from the rules on the current inputs.
    task automatic model_edge();
        bit h[NCH];
        bit hw;
        bit any;
        bit clr;
        int c;
        if (!reset) begin
            for (int i = 0; i < NCH; i++) begin
                m_pre[i] = 0; m_stall[i] = 0; m_thr[i] = BW;
            end
            m_wdog = 0; m_fired = 0; m_cause = 3'b000; m_cnt = 0;
            return;
        end
        hw  = (m_wdog >= WL);
        any = hw;
        for (int i = 0; i < NCH; i++) begin
            h[i] = (m_stall[i] >= m_thr[i]);
            any  = any | h[i];
        end
        clr = done || (m_fired && irq_ack);
        for (int i = 0; i < NCH; i++) begin
            c = int'(cov[i*COV_W +: COV_W]);
            if (enable) begin
                if (c != m_pre[i]) begin
                    m_pre[i] = c;
                    m_thr[i] = BW * ((c >> SS) + 1);
                    m_stall[i] = 0;
                end else begin
                    m_stall[i]++;
                end
            end
            if (clr) m_stall[i] = 0;
        end
        if (enable) m_wdog++;
        if (clr) m_wdog = 0;
        if (!m_fired) begin
            if (enable && any && !clr) begin
                m_fired = 1;
                m_cause = {hw, h[1], h[0]};
                m_cnt   = (m_cnt == 16'hFFFF) ? m_cnt : m_cnt + 1;
            end
        end else if (clr) begin
            m_fired = 0;
            m_cause = 3'b000;
        end
    endtask

    task automatic step(input bit en, input bit d, input bit ack,
                        input int c0, input int c1, input bit rst = 1'b1);
        reset   = rst;
        enable  = en;
        done    = d;
        irq_ack = ack;
        cov     = {c1[7:0], c0[7:0]};
        model_edge();
        @(posedge clock);
        #1;
        chk("model_irq", 32'(irq), 32'(m_fired));
        chk("model_cause", 32'(cause), 32'(m_cause));
        chk("model_fire_count", 32'(fire_count), 32'(m_cnt));
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
    endtask

    initial begin
        int r0;
        int r1;
        bit d;
        bit ack;
        bit en;
        bit rst;

        // Reset state
        do_reset();
        chk("reset_irq", 32'(irq), 32'd0);
        chk("reset_cause", 32'(cause), 32'd0);
        chk("reset_fire_count", 32'(fire_count), 32'd0);

        // 1: both channels stalled at 0
        repeat (4) step(1'b1, 1'b0, 1'b0, 0, 0);
        chk("t1_irq_edge4", 32'(irq), 32'd0);
        step(1'b1, 1'b0, 1'b0, 0, 0);
        chk("t1_irq_edge5", 32'(irq), 32'd1);
        chk("t1_cause", 32'(cause), 32'b011);
        chk("t1_fire_count", 32'(fire_count), 32'd1);

        // 2: ch1 constant 8'h10 -> threshold 8 counted after the update edge
        do_reset();
        for (int e = 1; e <= 9; e++) step(1'b1, 1'b0, 1'b0, e, 8'h10);
        chk("t2_irq_edge9", 32'(irq), 32'd0);
        step(1'b1, 1'b0, 1'b0, 10, 8'h10);
        chk("t2_irq_edge10", 32'(irq), 32'd1);
        chk("t2_cause", 32'(cause), 32'b010);

        // 3: both channels moving, watchdog expires
        do_reset();
        for (int e = 1; e <= 20; e++) step(1'b1, 1'b0, 1'b0, e, e + 100);
        chk("t3_irq_edge20", 32'(irq), 32'd0);
        step(1'b1, 1'b0, 1'b0, 21, 121);
        chk("t3_irq_edge21", 32'(irq), 32'd1);
        chk("t3_cause", 32'(cause), 32'b100);

        // 4: done at edge 3 restarts stall counting
        do_reset();
        step(1'b1, 1'b0, 1'b0, 0, 0);
        step(1'b1, 1'b0, 1'b0, 0, 0);
        step(1'b1, 1'b1, 1'b0, 0, 0);
        repeat (4) step(1'b1, 1'b0, 1'b0, 0, 0);
        chk("t4_irq_edge7", 32'(irq), 32'd0);
        step(1'b1, 1'b0, 1'b0, 0, 0);
        chk("t4_irq_edge8", 32'(irq), 32'd1);
        chk("t4_cause", 32'(cause), 32'b011);

        // 5: ack while still stalled, then done+ack together
        step(1'b1, 1'b0, 1'b1, 0, 0);
        chk("t5_ack_irq", 32'(irq), 32'd0);
        chk("t5_ack_cause", 32'(cause), 32'd0);
        repeat (4) step(1'b1, 1'b0, 1'b0, 0, 0);
        chk("t5_refire_early", 32'(irq), 32'd0);
        step(1'b1, 1'b0, 1'b0, 0, 0);
        chk("t5_refire_irq", 32'(irq), 32'd1);
        chk("t5_fire_count", 32'(fire_count), 32'd2);
        step(1'b1, 1'b1, 1'b1, 0, 0);
        chk("t5_both_irq", 32'(irq), 32'd0);
        chk("t5_both_cause", 32'(cause), 32'd0);
        repeat (4) step(1'b1, 1'b0, 1'b0, 0, 0);
        chk("t5_both_early", 32'(irq), 32'd0);
        step(1'b1, 1'b0, 1'b0, 0, 0);
        chk("t5_both_refire", 32'(irq), 32'd1);
        chk("t5_both_count", 32'(fire_count), 32'd3);

        // 6: reset mid-FIRED, then saturation of fire_count
        do_reset();
        repeat (5) step(1'b1, 1'b0, 1'b0, 0, 0);
        step(1'b1, 1'b0, 1'b1, 0, 0);
        repeat (5) step(1'b1, 1'b0, 1'b0, 0, 0);
        chk("t6_pre_count", 32'(fire_count), 32'd2);
        step(1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
        chk("t6_rst_irq", 32'(irq), 32'd0);
        chk("t6_rst_cause", 32'(cause), 32'd0);
        chk("t6_rst_count", 32'(fire_count), 32'd0);
        force dut.fire_count_q = 16'hFFFF;
        m_cnt = 16'hFFFF;
        step(1'b1, 1'b0, 1'b0, 0, 0);
        release dut.fire_count_q;
        repeat (4) step(1'b1, 1'b0, 1'b0, 0, 0);
        chk("t6_sat_irq", 32'(irq), 32'd1);
        chk("t6_sat_count", 32'(fire_count), 32'hFFFF);

        // Randomized traffic against the model
        do_reset();
        r0 = 0;
        r1 = 0;
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(9) == 0) r0 = int'($urandom_range(255));
            if ($urandom_range(9) == 0) r1 = int'($urandom_range(255));
            en  = ($urandom_range(7) != 0);
            d   = ($urandom_range(29) == 0);
            ack = ($urandom_range(5) == 0);
            rst = ($urandom_range(199) != 0);
            step(en, d, ack, r0, r1, rst);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
